// File: rtl/program_loader.sv
// Boot-time program loader: turns a UART byte stream (length, big-endian words, XOR checksum)
// into consecutive single-cycle writes on the block RAM port, then reports done or err.
module program_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 20001,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_di,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       word_cnt
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLen  = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StCsum = 3'd3;
    localparam logic [2:0] StDone = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_di_q, mem_di_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Previous three bytes plus the current one form the big-endian word or length.
    logic [31:0] shifted;
    assign shifted = {shift_q, rx_data};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        csum_d     = csum_q;
        word_cnt_d = word_cnt_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLen;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_cnt_d = 32'd0;
                    csum_d     = 8'd0;
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'd0;
                end
            end

            StLen: begin
                if (rx_valid) begin
                    shift_d    = shifted[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        len_d = shifted;
                        if (shifted > DEPTH) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else if (shifted == 32'd0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end

            StData: begin
                if (rx_valid) begin
                    shift_d    = shifted[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    csum_d     = csum_q ^ rx_data;
                    if (byte_cnt_q == 2'd3) begin
                        // Write lands in the following cycle; the FSM moves on at the same edge
                        // so a byte arriving during the write cycle is already handled.
                        mem_en_d   = 1'b1;
                        mem_di_d   = shifted;
                        mem_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
                        word_cnt_d = word_cnt_q + 32'd1;
                        if (word_cnt_q + 32'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end

            StCsum: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            len_q      <= 32'd0;
            csum_q     <= 8'd0;
            word_cnt_q <= 32'd0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= ADDR_W'(BASE_ADDR);
            mem_di_q   <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            word_cnt_q <= word_cnt_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: stream-position reference model checked every cycle, plus literal
// expectations for the directed loads.
module tb_program_loader;

    localparam int unsigned DEPTH = 20001;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        mem_en, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_di, word_cnt;

    program_loader #(.BASE_ADDR(0), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] di;
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] wc;
    } exp_t;

    exp_t        ex;
    logic        chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] load_words[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_we", 32'(mem_we), 32'(ex.we));
            check("mem_en", 32'(mem_en), 32'(ex.we));
            if (ex.we) begin
                check("mem_addr", mem_addr, ex.addr);
                check("mem_di", mem_di, ex.di);
            end
            check("busy", 32'(busy), 32'(ex.busy));
            check("done", 32'(done), 32'(ex.done));
            check("err", 32'(err), 32'(ex.err));
            check("word_cnt", word_cnt, ex.wc);
        end
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_di);
        end
    end

    // Drive one cycle of inputs; e is what the outputs must show after this edge.
    task automatic step(input logic v, input logic [7:0] d, input logic st, input exp_t e);
        rx_valid = v;
        rx_data  = d;
        start    = st;
        @(posedge clk);
        ex = e;
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        ex = '0;
        #1;
        rst = 1'b0;
    endtask

    // One load of length n with payload load_words. abort_at >= 0 resets after that byte index.
    task automatic run_load(input logic [31:0] n, input logic bad_csum, input int gap_max,
                            input logic start_all, input int abort_at);
        logic [7:0] bytes[$];
        logic [7:0] csum;
        exp_t       e;
        int         j;
        csum = 8'd0;
        bytes.push_back(n[31:24]);
        bytes.push_back(n[23:16]);
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        if (n <= DEPTH) begin
            for (int w = 0; w < int'(n); w++) begin
                for (int b = 3; b >= 0; b--) begin
                    bytes.push_back(8'(load_words[w] >> (8 * b)));
                    csum = csum ^ 8'(load_words[w] >> (8 * b));
                end
            end
            if (bad_csum) csum = csum ^ 8'($urandom_range(1, 255));
            bytes.push_back(csum);
        end
        wr_addr_q.delete();
        wr_data_q.delete();

        e      = ex;
        e.we   = 1'b0;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.err  = 1'b0;
        e.wc   = 32'd0;
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, e);

        for (int i = 0; i < bytes.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                e.we = 1'b0;
                step(1'b0, 8'($urandom), start_all || ($urandom_range(0, 3) == 0), e);
            end
            e.we = 1'b0;
            if (i < 4) begin
                if (i == 3 && n > DEPTH) begin
                    e.busy = 1'b0;
                    e.err  = 1'b1;
                end
            end else if (i < 4 + 4 * int'(n)) begin
                j    = i - 4;
                e.wc = 32'((j + 1) / 4);
                if (j % 4 == 3) begin
                    e.we   = 1'b1;
                    e.addr = 32'(j / 4);
                    e.di   = load_words[j / 4];
                end
            end else begin
                e.busy = 1'b0;
                e.done = !bad_csum;
                e.err  = bad_csum;
            end
            step(1'b1, bytes[i], start_all || ($urandom_range(0, 3) == 0), e);
            if (i == abort_at) begin
                do_reset();
                return;
            end
        end
        // Trailing bytes after the load must be ignored.
        repeat (3) begin
            e.we = 1'b0;
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, e);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        ex       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_di", mem_di, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Test 1: two words; the XOR of the data bytes is 0x00.
        load_words = '{32'h12345678, 32'h9ABCDEF0};
        run_load(32'd2, 1'b0, 1, 1'b0, -1);
        check("t1 write count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("t1 addr0", wr_addr_q[0], 32'd0);
            check("t1 data0", wr_data_q[0], 32'h12345678);
            check("t1 addr1", wr_addr_q[1], 32'd1);
            check("t1 data1", wr_data_q[1], 32'h9ABCDEF0);
        end
        check("t1 done", 32'(done), 32'd1);
        check("t1 err", 32'(err), 32'd0);
        check("t1 word_cnt", word_cnt, 32'd2);

        // Test 2: same stream, checksum byte 0x09 mismatches.
        begin
            exp_t e;
            logic [7:0] bs[12];
            bs = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h9A, 8'hBC, 8'hDE, 8'hF0};
            wr_addr_q.delete();
            wr_data_q.delete();
            e = '0;
            e.busy = 1'b1;
            step(1'b0, 8'h00, 1'b1, e);
            for (int i = 0; i < 12; i++) begin
                e.we = (i == 7) || (i == 11);
                e.addr = (i == 11) ? 32'd1 : 32'd0;
                e.di = (i == 11) ? 32'h9ABCDEF0 : 32'h12345678;
                e.wc = (i >= 11) ? 32'd2 : (i >= 7) ? 32'd1 : 32'd0;
                step(1'b1, bs[i], 1'b0, e);
            end
            e.we = 1'b0;
            e.busy = 1'b0;
            e.err = 1'b1;
            step(1'b1, 8'h09, 1'b0, e);
            @(negedge clk);
            check("t2 write count", 32'(wr_addr_q.size()), 32'd2);
            check("t2 err", 32'(err), 32'd1);
            check("t2 done", 32'(done), 32'd0);
            check("t2 busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end

        // Test 3: length DEPTH+1 is rejected on the 4th length byte.
        run_load(32'd20002, 1'b0, 1, 1'b0, -1);
        check("t3 write count", 32'(wr_addr_q.size()), 32'd0);
        check("t3 err", 32'(err), 32'd1);

        // Test 4: empty load, checksum 00.
        run_load(32'd0, 1'b0, 1, 1'b0, -1);
        check("t4 write count", 32'(wr_addr_q.size()), 32'd0);
        check("t4 done", 32'(done), 32'd1);
        check("t4 word_cnt", word_cnt, 32'd0);

        // Test 5: back-to-back bytes, three words.
        load_words = '{$urandom, $urandom, $urandom};
        run_load(32'd3, 1'b0, 0, 1'b0, -1);
        check("t5 write count", 32'(wr_addr_q.size()), 32'd3);
        check("t5 done", 32'(done), 32'd1);

        // Test 6: reset right after the first write, then a clean load with start held mid-load.
        load_words = '{32'h11223344, 32'h55667788};
        run_load(32'd2, 1'b0, 0, 1'b0, 7);
        @(negedge clk);
        check("t6 rst mem_addr", mem_addr, 32'd0);
        check("t6 rst mem_di", mem_di, 32'd0);
        check("t6 rst word_cnt", word_cnt, 32'd0);
        check("t6 rst flags", {28'd0, busy, done, err, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        load_words = '{32'hCAFEBABE};
        run_load(32'd1, 1'b0, 2, 1'b1, -1);
        check("t6 write count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("t6 addr", wr_addr_q[0], 32'd0);
            check("t6 data", wr_data_q[0], 32'hCAFEBABE);
        end
        check("t6 done", 32'(done), 32'd1);

        // Randomized loads.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] n;
            n = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) n = DEPTH + 1 + $urandom_range(0, 1000);
            load_words.delete();
            for (int w = 0; w < 5; w++) load_words.push_back($urandom);
            run_load(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b0, -1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
